// File: rtl/adu_addr_collector.sv
// Collects low/high address bytes in either order and holds the assembled address for the consumer until ack.
// valid rises on the edge that samples the second byte; ADU_ADDR_COLLECTOR_BURST_EN makes ack+inc step the address in FULL.
module adu_addr_collector #(
  parameter int              BW       = 8,
  parameter logic [2*BW-1:0] RST_ADDR = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [BW-1:0]   d_i,
  input  logic            dl_i,
  input  logic            dh_i,
  input  logic            inc_i,
  input  logic            ack_i,
  output logic [2*BW-1:0] addr_o,
  output logic            valid_o,
  output logic            err_o
);

  typedef enum logic [1:0] {EMPTY, HAVE_LO, HAVE_HI, FULL} state_e;

`ifdef ADU_ADDR_COLLECTOR_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam logic [2*BW-1:0] ONE = {{(2*BW-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [2*BW-1:0] addr_q, addr_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    if (dl_i && dh_i) begin
      // Simultaneous strobes are ambiguous: nothing is loaded and nothing moves.
      err_d = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (dl_i) begin
            addr_d[BW-1:0] = d_i;
            state_d        = HAVE_LO;
          end else if (dh_i) begin
            addr_d[2*BW-1:BW] = d_i;
            state_d           = HAVE_HI;
          end
        end
        HAVE_LO: begin
          if (dl_i) begin
            addr_d[BW-1:0] = d_i;
          end else if (dh_i) begin
            addr_d[2*BW-1:BW] = d_i;
            state_d           = FULL;
          end
        end
        HAVE_HI: begin
          if (dh_i) begin
            addr_d[2*BW-1:BW] = d_i;
          end else if (dl_i) begin
            addr_d[BW-1:0] = d_i;
            state_d        = FULL;
          end
        end
        FULL: begin
          if (BURST && ack_i && inc_i) begin
            addr_d = addr_q + ONE;
          end else if (ack_i) begin
            // The freed collector takes a strobe arriving with ack, so transfers can run back to back.
            state_d = EMPTY;
            if (dl_i) begin
              addr_d[BW-1:0] = d_i;
              state_d        = HAVE_LO;
            end else if (dh_i) begin
              addr_d[2*BW-1:BW] = d_i;
              state_d           = HAVE_HI;
            end
          end else begin
            if (dl_i || dh_i) err_d = 1'b1;
            if (inc_i) addr_d = addr_q + ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      addr_q  <= RST_ADDR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign addr_o  = addr_q;
  assign valid_o = (state_q == FULL);
  assign err_o   = err_q;

endmodule

// File: tb/tb_adu_addr_collector.sv
// Scoreboard bench: directed plan cases then constrained-random cycles against a byte-flag reference model.
module tb_adu_addr_collector;

  localparam logic [15:0] RST_ADDR = 16'hA5C3;
`ifdef ADU_ADDR_COLLECTOR_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic        valid;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, dl, dh, inc, ack;
  logic [7:0]  d;
  logic [15:0] addr;
  logic        valid, err;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: which bytes are held, the address value and the sticky error.
  bit          m_lo, m_hi, m_err;
  logic [15:0] m_addr;

  always #5 clk = ~clk;

  adu_addr_collector #(.BW(8), .RST_ADDR(RST_ADDR)) dut (
    .clk_i(clk), .rst_i(rst), .d_i(d), .dl_i(dl), .dh_i(dh),
    .inc_i(inc), .ack_i(ack), .addr_o(addr), .valid_o(valid), .err_o(err)
  );

  task automatic step(input bit r, input logic [7:0] dv, input bit l, input bit h,
                      input bit i, input bit a);
    exp_t e;
    bit   full;
    @(negedge clk);
    rst = r; d = dv; dl = l; dh = h; inc = i; ack = a;
    full = m_lo && m_hi;
    if (r) begin
      m_lo = 0; m_hi = 0; m_err = 0; m_addr = RST_ADDR;
    end else if (l && h) begin
      m_err = 1;
    end else if (full) begin
      if (a && i && BURST) begin
        m_addr = m_addr + 16'd1;
      end else if (a) begin
        m_lo = 0; m_hi = 0;
        if (l) begin m_addr[7:0] = dv;  m_lo = 1; end
        if (h) begin m_addr[15:8] = dv; m_hi = 1; end
      end else begin
        if (l || h) m_err = 1;
        if (i) m_addr = m_addr + 16'd1;
      end
    end else begin
      if (l) begin m_addr[7:0] = dv;  m_lo = 1; end
      if (h) begin m_addr[15:8] = dv; m_hi = 1; end
    end
    e.addr = m_addr; e.valid = m_lo && m_hi; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 8'h00, 0, 0, 0, 0);
  endtask

  // Monitor: every edge after stimulus was issued yields one observed output to score.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (addr !== e.addr || valid !== e.valid || err !== e.err) begin
          n_bad++;
          $display("FAIL out_check cyc=%0d got addr=%h valid=%b err=%b, want addr=%h valid=%b err=%b",
                   cyc, addr, valid, err, e.addr, e.valid, e.err);
        end
      end
    end
  end

  initial begin
    bit   l, h, i, a, r;
    int   s, wait_cyc;
    rst = 1; d = 0; dl = 0; dh = 0; inc = 0; ack = 0;
    m_lo = 0; m_hi = 0; m_err = 0; m_addr = RST_ADDR;

    step(1, 8'h00, 0, 0, 0, 0);
    // Low then high, then ack keeps the address.
    step(0, 8'h0E, 1, 0, 0, 0);
    step(0, 8'h7A, 0, 1, 0, 0);
    idle(1);
    step(0, 8'h00, 0, 0, 0, 1);
    idle(1);
    // High then low, then a stray low byte while full.
    step(0, 8'h4E, 0, 1, 0, 0);
    step(0, 8'h20, 1, 0, 0, 0);
    step(0, 8'h33, 1, 0, 0, 0);
    idle(2);
    step(0, 8'h00, 0, 0, 0, 1);
    idle(1);
    step(1, 8'h00, 0, 0, 0, 0);
    // Wrap on increment.
    step(0, 8'hFF, 1, 0, 0, 0);
    step(0, 8'hFF, 0, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1, 0);
    step(0, 8'h00, 0, 0, 1, 0);
    step(0, 8'h00, 0, 0, 1, 0);
    // Ack with a low strobe refills the collector.
    step(0, 8'h55, 1, 0, 0, 1);
    idle(1);
    step(1, 8'h00, 0, 0, 0, 0);
    step(0, 8'hAA, 1, 1, 0, 0);
    idle(1);
    step(0, 8'h11, 1, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0, 0);
    // Ack together with inc for three cycles.
    step(0, 8'h00, 1, 0, 0, 0);
    step(0, 8'h10, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 8'h00, 0, 0, 1, 1);
    idle(1);
    step(0, 8'h00, 0, 0, 0, 1);
    idle(1);

    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 59) == 0);
      s = $urandom_range(0, 15);
      l = (s < 5) || (s == 15);
      h = (s >= 5 && s < 10) || (s == 15);
      i = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 2) == 0);
      if (l && h) begin i = 0; a = 0; end
      if (m_lo && m_hi && (l || h) && !a) i = 0;
      if (a && i) begin l = 0; h = 0; end
      step(r, 8'($urandom), l, h, i, a);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
